// File: rtl/alu_sequencer.sv
// Multi-byte operation sequencer driving an 8-bit combinational ALU one byte per cycle,
// chaining carry/shift bits between bytes and assembling result and flags.
module alu_sequencer #(
  parameter int unsigned NBYTES = 2
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  START,
  input  logic [2:0]            OP,
  input  logic [8*NBYTES-1:0]   OPA,
  input  logic [8*NBYTES-1:0]   OPB,
  input  logic                  CIN_INIT,
  input  logic                  SIN_INIT,
  output logic [7:0]            ALU_A,
  output logic [7:0]            ALU_B,
  output logic [2:0]            ALU_OP,
  output logic                  ALU_CIN,
  output logic                  ALU_SIN,
  input  logic [7:0]            ALU_OUT,
  input  logic                  ALU_COUT,
  input  logic                  ALU_SOUT,
  input  logic                  ALU_ZERO,
  output logic [8*NBYTES-1:0]   RESULT,
  output logic                  CARRY,
  output logic                  SHOUT,
  output logic                  ZERO,
  output logic                  BUSY,
  output logic                  DONE
);

  localparam int unsigned IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  // Opcode encoding shared with the ALU (XOR=4, AND=5, OR=6 pass straight through)
  localparam logic [2:0] K_ADD  = 3'd0;
  localparam logic [2:0] K_SUB  = 3'd1;
  localparam logic [2:0] K_SHL  = 3'd2;
  localparam logic [2:0] K_SHR  = 3'd3;
  localparam logic [2:0] K_PASS = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [2:0]               op_q, op_d;
  logic [NBYTES-1:0][7:0]   opa_q, opa_d;
  logic [NBYTES-1:0][7:0]   opb_q, opb_d;
  logic [NBYTES-1:0][7:0]   result_q, result_d;
  logic [IDXW-1:0]          idx_q, idx_d;
  logic                     chain_q, chain_d;
  logic                     zacc_q, zacc_d;
  logic                     carry_q, carry_d;
  logic                     shout_q, shout_d;
  logic                     zero_q, zero_d;

  logic accept;
  logic last_byte;
  logic is_arith;
  logic is_shift;

  assign accept    = START && ((state_q == S_IDLE) || (state_q == S_FIN));
  assign is_arith  = (op_q == K_ADD) || (op_q == K_SUB);
  assign is_shift  = (op_q == K_SHL) || (op_q == K_SHR);
  // SHR walks bytes from the top down so the shift-in bit enters at the MSB
  assign last_byte = (op_q == K_SHR) ? (idx_q == '0)
                                     : (idx_q == IDXW'(NBYTES - 1));

  // State register
  always_ff @(posedge CLK) begin
    if (RESET) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (START) state_d = S_RUN;
      S_RUN:   if (last_byte) state_d = S_FIN;
      S_FIN:   state_d = START ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ALU drive: quiet PASS of zeros outside RUN
  always_comb begin
    ALU_A   = 8'h00;
    ALU_B   = 8'h00;
    ALU_OP  = K_PASS;
    ALU_CIN = 1'b0;
    ALU_SIN = 1'b0;
    if (state_q == S_RUN) begin
      ALU_A = opa_q[idx_q];
      case (op_q)
        K_ADD: begin
          ALU_OP  = K_ADD;
          ALU_B   = opb_q[idx_q];
          ALU_CIN = chain_q;
        end
        // ALU subtract has no usable borrow, so add the inverted operand instead
        K_SUB: begin
          ALU_OP  = K_ADD;
          ALU_B   = ~opb_q[idx_q];
          ALU_CIN = chain_q;
        end
        K_SHL, K_SHR: begin
          ALU_OP  = op_q;
          ALU_B   = 8'h01;
          ALU_SIN = chain_q;
        end
        default: begin
          ALU_OP = op_q;
          ALU_B  = opb_q[idx_q];
        end
      endcase
    end
  end

  // Datapath next-state
  always_comb begin
    op_d     = op_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    result_d = result_q;
    idx_d    = idx_q;
    chain_d  = chain_q;
    zacc_d   = zacc_q;
    carry_d  = carry_q;
    shout_d  = shout_q;
    zero_d   = zero_q;
    if (accept) begin
      op_d     = OP;
      opa_d    = OPA;
      opb_d    = OPB;
      result_d = '0;
      zacc_d   = 1'b1;
      chain_d  = ((OP == K_SHL) || (OP == K_SHR)) ? SIN_INIT : CIN_INIT;
      idx_d    = (OP == K_SHR) ? IDXW'(NBYTES - 1) : '0;
    end else if (state_q == S_RUN) begin
      result_d[idx_q] = ALU_OUT;
      chain_d = is_arith ? ALU_COUT : (is_shift ? ALU_SOUT : 1'b0);
      zacc_d  = zacc_q & ALU_ZERO;
      idx_d   = (op_q == K_SHR) ? (idx_q - IDXW'(1)) : (idx_q + IDXW'(1));
      if (last_byte) begin
        carry_d = is_arith ? ALU_COUT : 1'b0;
        shout_d = is_shift ? ALU_SOUT : 1'b0;
        zero_d  = zacc_q & ALU_ZERO;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      op_q     <= K_PASS;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      idx_q    <= '0;
      chain_q  <= 1'b0;
      zacc_q   <= 1'b0;
      carry_q  <= 1'b0;
      shout_q  <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      op_q     <= op_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      idx_q    <= idx_d;
      chain_q  <= chain_d;
      zacc_q   <= zacc_d;
      carry_q  <= carry_d;
      shout_q  <= shout_d;
      zero_q   <= zero_d;
    end
  end

  assign RESULT = result_q;
  assign CARRY  = carry_q;
  assign SHOUT  = shout_q;
  assign ZERO   = zero_q;
  assign BUSY   = (state_q == S_RUN);
  assign DONE   = (state_q == S_FIN);

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural 8-bit ALU and a word-level
// reference model feeding an expected-result queue.
module tb_alu_sequencer;

  localparam int unsigned NB = 2;
  localparam int unsigned W  = 8 * NB;

  localparam logic [2:0] K_ADD  = 3'd0;
  localparam logic [2:0] K_SUB  = 3'd1;
  localparam logic [2:0] K_SHL  = 3'd2;
  localparam logic [2:0] K_SHR  = 3'd3;
  localparam logic [2:0] K_XOR  = 3'd4;
  localparam logic [2:0] K_AND  = 3'd5;
  localparam logic [2:0] K_OR   = 3'd6;
  localparam logic [2:0] K_PASS = 3'd7;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   op_i;
  logic [W-1:0] opa_i, opb_i;
  logic         cin_init, sin_init;
  logic [7:0]   alu_a, alu_b, alu_out;
  logic [2:0]   alu_op;
  logic         alu_cin, alu_sin, alu_cout, alu_sout, alu_zero;
  logic [W-1:0] result;
  logic         carry, shout, zero, busy, done;

  typedef struct packed {
    logic [W-1:0] result;
    logic         carry;
    logic         shout;
    logic         zero;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  alu_sequencer #(.NBYTES(NB)) dut (
    .CLK(clk), .RESET(reset), .START(start), .OP(op_i), .OPA(opa_i), .OPB(opb_i),
    .CIN_INIT(cin_init), .SIN_INIT(sin_init),
    .ALU_A(alu_a), .ALU_B(alu_b), .ALU_OP(alu_op), .ALU_CIN(alu_cin), .ALU_SIN(alu_sin),
    .ALU_OUT(alu_out), .ALU_COUT(alu_cout), .ALU_SOUT(alu_sout), .ALU_ZERO(alu_zero),
    .RESULT(result), .CARRY(carry), .SHOUT(shout), .ZERO(zero), .BUSY(busy), .DONE(done)
  );

  // Behavioural combinational 8-bit ALU; shifts are single-bit
  always_comb begin
    alu_out  = 8'h00;
    alu_cout = 1'b0;
    alu_sout = 1'b0;
    case (alu_op)
      K_ADD:  {alu_cout, alu_out} = 9'(alu_a) + 9'(alu_b) + 9'(alu_cin);
      K_SUB:  {alu_cout, alu_out} = 9'(alu_a) - 9'(alu_b);
      K_SHL:  begin alu_out = {alu_a[6:0], alu_sin}; alu_sout = alu_a[7]; end
      K_SHR:  begin alu_out = {alu_sin, alu_a[7:1]}; alu_sout = alu_a[0]; end
      K_XOR:  alu_out = alu_a ^ alu_b;
      K_AND:  alu_out = alu_a & alu_b;
      K_OR:   alu_out = alu_a | alu_b;
      default: alu_out = alu_a;
    endcase
    alu_zero = (alu_out == 8'h00);
  end

  function automatic exp_t ref_model(input logic [2:0] op, input logic [W-1:0] a,
                                     input logic [W-1:0] b, input logic cin, input logic sin);
    exp_t       e;
    logic [W:0] s;
    e = '0;
    s = '0;
    case (op)
      K_ADD: begin
        s = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
        e.result = s[W-1:0]; e.carry = s[W];
      end
      K_SUB: begin
        s = {1'b0, a} + {1'b0, ~b} + (W+1)'(cin);
        e.result = s[W-1:0]; e.carry = s[W];
      end
      K_SHL: begin e.result = {a[W-2:0], sin}; e.shout = a[W-1]; end
      K_SHR: begin e.result = {sin, a[W-1:1]}; e.shout = a[0]; end
      K_XOR: e.result = a ^ b;
      K_AND: e.result = a & b;
      K_OR:  e.result = a | b;
      default: e.result = a;
    endcase
    e.zero = (e.result == '0);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive a request in the current cycle and record its expected outcome
  task automatic launch(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sin);
    start = 1'b1; op_i = op; opa_i = a; opb_i = b; cin_init = cin; sin_init = sin;
    sb_q.push_back(ref_model(op, a, b, cin, sin));
    @(negedge clk);
    start = 1'b0;
  endtask

  // Check every RUN cycle's ALU drive; optionally pulse START while busy
  task automatic run_check(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic cin, input logic sin, input bit poke);
    int unsigned idx;
    logic [7:0]  eb;
    for (int k = 0; k < NB; k++) begin
      idx = (op == K_SHR) ? (NB - 1 - k) : k;
      eb  = (op == K_SUB) ? ~b[8*idx +: 8] :
            ((op == K_SHL) || (op == K_SHR)) ? 8'h01 : b[8*idx +: 8];
      chk("busy_run", W'(busy), W'(1'b1));
      chk("done_run", W'(done), W'(1'b0));
      chk("alu_a", W'(alu_a), W'(a[8*idx +: 8]));
      chk("alu_b", W'(alu_b), W'(eb));
      chk("alu_op", W'(alu_op), W'((op == K_SUB) ? K_ADD : op));
      if (k == 0) begin
        chk("alu_cin0", W'(alu_cin), W'(((op == K_ADD) || (op == K_SUB)) ? cin : 1'b0));
        chk("alu_sin0", W'(alu_sin), W'(((op == K_SHL) || (op == K_SHR)) ? sin : 1'b0));
      end
      if (poke && (k == 0)) begin
        start = 1'b1; op_i = K_PASS; opa_i = ~a; opb_i = ~b;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  // FIN cycle: DONE pulse, then compare against the oldest expectation
  task automatic finish_check(input string tag);
    exp_t e;
    chk({tag, "_done"}, W'(done), W'(1'b1));
    chk({tag, "_busy"}, W'(busy), W'(1'b0));
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_result"}, result, e.result);
      chk({tag, "_carry"}, W'(carry), W'(e.carry));
      chk({tag, "_shout"}, W'(shout), W'(e.shout));
      chk({tag, "_zero"}, W'(zero), W'(e.zero));
    end
  endtask

  task automatic do_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic cin, input logic sin);
    launch(op, a, b, cin, sin);
    run_check(op, a, b, cin, sin, 1'b0);
    finish_check(tag);
    @(negedge clk);
  endtask

  initial begin
    logic [2:0]   rop;
    logic [W-1:0] ra, rb;
    logic         rc, rs;
    reset = 1'b1; start = 1'b0; op_i = K_PASS; opa_i = '0; opb_i = '0;
    cin_init = 1'b0; sin_init = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", W'(busy), W'(1'b0));
    chk("rst_done", W'(done), W'(1'b0));
    chk("rst_result", result, '0);
    chk("rst_flags", W'({carry, shout, zero}), W'(3'b000));
    reset = 1'b0;
    @(negedge clk);
    chk("idle_alu_op", W'(alu_op), W'(K_PASS));
    chk("idle_alu_a", W'(alu_a), W'(8'h00));

    do_op("add1", K_ADD, 16'h00FF, 16'h0001, 1'b0, 1'b0);
    do_op("add2", K_ADD, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    do_op("sub1", K_SUB, 16'h0100, 16'h0001, 1'b1, 1'b0);
    do_op("sub2", K_SUB, 16'h0000, 16'h0001, 1'b1, 1'b0);
    do_op("shl",  K_SHL, 16'h8080, 16'h0000, 1'b0, 1'b1);
    do_op("shr",  K_SHR, 16'h0101, 16'h0000, 1'b0, 1'b0);

    // START while busy must be ignored
    launch(K_XOR, 16'hF0F0, 16'hFF00, 1'b0, 1'b0);
    run_check(K_XOR, 16'hF0F0, 16'hFF00, 1'b0, 1'b0, 1'b1);
    finish_check("xor");
    @(negedge clk);
    chk("xor_no_relaunch_busy", W'(busy), W'(1'b0));
    chk("xor_no_relaunch_done", W'(done), W'(1'b0));

    // Back-to-back: START held in FIN launches straight into RUN
    launch(K_AND, 16'h3C5A, 16'h0FF0, 1'b0, 1'b0);
    run_check(K_AND, 16'h3C5A, 16'h0FF0, 1'b0, 1'b0, 1'b0);
    finish_check("and");
    launch(K_OR, 16'h1200, 16'h0034, 1'b0, 1'b0);
    run_check(K_OR, 16'h1200, 16'h0034, 1'b0, 1'b0, 1'b0);
    finish_check("or");
    launch(K_PASS, 16'hA5C3, 16'h1111, 1'b1, 1'b1);
    run_check(K_PASS, 16'hA5C3, 16'h1111, 1'b1, 1'b1, 1'b0);
    finish_check("pass");
    @(negedge clk);

    // Reset in the second RUN cycle aborts with no DONE
    launch(K_ADD, 16'h1234, 16'h1111, 1'b0, 1'b0);
    chk("abort_busy0", W'(busy), W'(1'b1));
    @(negedge clk);
    chk("abort_busy1", W'(busy), W'(1'b1));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    void'(sb_q.pop_back());
    chk("abort_busy", W'(busy), W'(1'b0));
    chk("abort_done", W'(done), W'(1'b0));
    chk("abort_result", result, '0);
    chk("abort_flags", W'({carry, shout, zero}), W'(3'b000));
    @(negedge clk);
    chk("abort_no_done", W'(done), W'(1'b0));
    do_op("post_rst", K_ADD, 16'h1234, 16'h1111, 1'b0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = W'($urandom());
      rb  = W'($urandom());
      rc  = 1'($urandom_range(0, 1));
      rs  = 1'($urandom_range(0, 1));
      do_op("rand", rop, ra, rb, rc, rs);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Multi-byte operation sequencer that acts as the initiator for the 8-bit combinational ALU.
- Accepts one NBYTES-wide operation per START and latches the operands.
- Issues one ALU byte-operation per cycle on the ALU port group, chaining carry or shift bits between bytes.
- Accumulates the result, final carry, shift-out and zero flag, then signals DONE. Sits between the control unit and the ALU.

Parameters:
NBYTES, 2, number of 8-bit bytes per operand (>=1)

Ports:
CLK  in  1  clock
RESET  in  1  synchronous, active-high reset
START  in  1  request; sampled when not BUSY
OP  in  3  operation, op_mne encoding from definitions (kADD,kSUB,kSHL,kSHR,kXOR,kAND,kOR,kPASS)
OPA  in  8*NBYTES  operand A
OPB  in  8*NBYTES  operand B (ignored for shifts)
CIN_INIT  in  1  initial carry (ADD/SUB)
SIN_INIT  in  1  initial shift-in bit (SHL/SHR)
ALU_A  out  8  byte to ALU INPUTA
ALU_B  out  8  byte to ALU INPUTB
ALU_OP  out  3  opcode to ALU
ALU_CIN  out  1  to ALU C_IN
ALU_SIN  out  1  to ALU S_IN
ALU_OUT  in  8  from ALU OUT
ALU_COUT  in  1  from ALU C_OUT
ALU_SOUT  in  1  from ALU S_OUT
ALU_ZERO  in  1  from ALU ZERO
RESULT  out  8*NBYTES  assembled result
CARRY  out  1  final carry (ADD/SUB), else 0
SHOUT  out  1  final shifted-out bit (SHL/SHR), else 0
ZERO  out  1  1 iff entire RESULT == 0
BUSY  out  1  operation in progress
DONE  out  1  one-cycle completion pulse

Behaviour:
- Single clock CLK; RESET synchronous, active-high.
- Reset values: RESULT=0, CARRY=0, SHOUT=0, ZERO=0, BUSY=0, DONE=0, state IDLE.
- States: IDLE, RUN, FIN.
  - IDLE: START=1 latches OP, OPA, OPB, CIN_INIT and SIN_INIT, clears RESULT, loads the chain bit and sets the zero accumulator to 1. Next state RUN.
  - RUN: lasts exactly NBYTES cycles, one byte per cycle. Byte index counter: up from 0 for kADD, kSUB, kSHL, kXOR, kAND, kOR, kPASS; down from NBYTES-1 for kSHR.
  - FIN: one cycle, DONE=1. Returns to IDLE, or goes directly to RUN if START=1 in this cycle (back-to-back; new operands latched).
- BUSY=1 exactly in RUN cycles. START while BUSY is ignored.
- Latency: START sampled at edge N; DONE high in cycle N+NBYTES+1.
- RESULT, CARRY, SHOUT and ZERO hold their values until the next accepted START.
- ALU drive in RUN, where k is the current byte index:
  - ALU_A = OPA byte k.
  - kADD: ALU_OP=kADD, ALU_B=OPB byte k, ALU_CIN=chain.
  - kSUB: ALU_OP=kADD, ALU_B=~OPB byte k, ALU_CIN=chain. The ALU kSUB carry-out is unusable, so the sequencer substitutes add-with-inverted-B. CIN_INIT=1 gives plain A-B; final CARRY=1 means no borrow.
  - kSHL/kSHR: ALU_OP=OP, ALU_B=8'h01 (single-bit mode), ALU_SIN=chain.
  - Logic ops/kPASS: ALU_OP=OP, ALU_B=OPB byte k, ALU_CIN=ALU_SIN=0.
- Per RUN edge:
  - RESULT byte k <= ALU_OUT.
  - Chain <= ALU_COUT for ADD/SUB, ALU_SOUT for shifts, 0 otherwise.
  - Zero accumulator <= acc & ALU_ZERO.
- At the last RUN edge: CARRY <= chain source for ADD/SUB (else 0), SHOUT <= ALU_SOUT for shifts (else 0), ZERO <= final accumulator.
- Outside RUN: ALU_OP=kPASS; ALU_A, ALU_B, ALU_CIN, ALU_SIN all 0.
- RESET mid-operation: abort immediately; all outputs take reset values; no DONE is issued.
- NBYTES=1: RUN lasts one cycle.

Test Plan:
- NBYTES=2, kADD, OPA=16'h00FF, OPB=16'h0001, CIN_INIT=0 -> ALU_A sequence FF then 00. RESULT=16'h0100, CARRY=0, ZERO=0. DONE exactly 3 cycles after START edge; BUSY high 2 cycles.
- kADD, OPA=16'hFFFF, OPB=16'h0001 -> RESULT=16'h0000, CARRY=1, ZERO=1.
- kSUB, CIN_INIT=1: 16'h0100-16'h0001 -> RESULT=16'h00FF, CARRY=1. Then 16'h0000-16'h0001 -> RESULT=16'hFFFF, CARRY=0. Check ALU_OP=kADD and ALU_B=~OPB byte.
- kSHL, OPA=16'h8080, SIN_INIT=1 -> RESULT=16'h0101, SHOUT=1. kSHR, OPA=16'h0101, SIN_INIT=0 -> bytes issued MSB first, RESULT=16'h0080, SHOUT=1.
- kXOR, OPA=16'hF0F0, OPB=16'hFF00 -> RESULT=16'h0FF0, CARRY=0, SHOUT=0. Second START asserted during BUSY is ignored. START held in the FIN cycle launches the next operation with no IDLE gap.
- RESET asserted in the second RUN cycle -> next cycle BUSY=0, RESULT=0, state IDLE, no DONE pulse. A subsequent START completes normally.
